// File: rtl/pmp_seq_checker.sv
// Sequential PMP checker: walks the entries in priority order through a single
// shared pmp_entry matcher, two cycles per entry, then reports the verdict.
module pmp_entry #(
  parameter int unsigned PLEN    = 56,
  parameter int unsigned PMP_LEN = 54
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [PLEN-1:0]    addr_i,
  input  logic [PMP_LEN-1:0] conf_addr_i,
  input  logic [PMP_LEN-1:0] conf_addr_prev_i,
  input  logic [1:0]         mode_i,
  output logic               match_o
);
  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
  localparam logic [1:0] A_NAPOT = 2'd3;

  logic [PMP_LEN-1:0] napot_ones;
  logic [PLEN-1:0]    top_addr;
  logic [PLEN-1:0]    bot_addr;
  logic [PLEN-1:0]    napot_care;
  logic [PLEN-1:0]    base_reg;
  logic [PLEN-1:0]    care_reg;

  // Trailing ones plus the first zero, widened by the two implied byte bits,
  // are exactly the don't-care bits of the NAPOT region.
  assign napot_ones = conf_addr_i ^ (conf_addr_i + PMP_LEN'(1));
  assign napot_care = ~PLEN'({napot_ones, 2'b11});
  assign top_addr   = PLEN'({conf_addr_i, 2'b00});
  assign bot_addr   = PLEN'({conf_addr_prev_i, 2'b00});

  // NAPOT base/mask are registered to keep the carry chain off the compare path.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_reg <= '0;
      care_reg <= '0;
    end else begin
      base_reg <= top_addr & napot_care;
      care_reg <= napot_care;
    end
  end

  always_comb begin
    match_o = 1'b0;
    case (mode_i)
      A_TOR:   match_o = (addr_i >= bot_addr) && (addr_i < top_addr);
      A_NA4:   match_o = (addr_i[PLEN-1:2] == top_addr[PLEN-1:2]);
      A_NAPOT: match_o = ((addr_i & care_reg) == base_reg);
      default: match_o = 1'b0;
    endcase
  end
endmodule

module pmp_seq_checker #(
  parameter int unsigned PLEN       = 56,
  parameter int unsigned PMP_LEN    = 54,
  parameter int unsigned NR_ENTRIES = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                req_valid_i,
  output logic                                req_ready_o,
  input  logic [PLEN-1:0]                     addr_i,
  input  logic [2:0]                          access_i,
  input  logic                                priv_m_i,
  input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]  conf_addr_i,
  input  logic [NR_ENTRIES-1:0][7:0]          conf_i,
  output logic                                resp_valid_o,
  input  logic                                resp_ready_i,
  output logic                                allow_o,
  output logic                                match_found_o,
  output logic [3:0]                          match_idx_o
);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_EVAL, S_RESP} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NR_ENTRIES - 1);

  state_t             state_reg, state_next;
  logic [3:0]         idx_reg, idx_next;
  logic [PLEN-1:0]    addr_reg;
  logic [2:0]         access_reg;
  logic               priv_m_reg;
  logic               allow_reg, allow_next;
  logic               found_reg, found_next;
  logic [3:0]         match_idx_reg, match_idx_next;
  logic               capture;

  logic [NR_ENTRIES-1:0] sel_cur;
  logic [NR_ENTRIES-1:0] sel_prev;
  logic [PMP_LEN-1:0]    cur_addr;
  logic [PMP_LEN-1:0]    prev_addr;
  logic [7:0]            cur_cfg;
  logic                  entry_match;
  logic                  access_onehot;
  logic                  unused_cfg;

  for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_sel
    assign sel_cur[gi] = (idx_reg == 4'(gi));
    if (gi < NR_ENTRIES - 1) begin : g_prev
      assign sel_prev[gi] = (idx_reg == 4'(gi + 1));
    end else begin : g_noprev
      assign sel_prev[gi] = 1'b0;
    end
  end

  // Entry 0 has no predecessor, so its TOR bottom stays at zero.
  always_comb begin
    cur_addr  = '0;
    prev_addr = '0;
    cur_cfg   = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (sel_cur[i]) begin
        cur_addr = conf_addr_i[i];
        cur_cfg  = conf_i[i];
      end
      if (sel_prev[i]) prev_addr = conf_addr_i[i];
    end
  end

  assign unused_cfg = ^cur_cfg[6:5];

  pmp_entry #(
    .PLEN    (PLEN),
    .PMP_LEN (PMP_LEN)
  ) u_entry (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .addr_i           (addr_reg),
    .conf_addr_i      (cur_addr),
    .conf_addr_prev_i (prev_addr),
    .mode_i           (cur_cfg[4:3]),
    .match_o          (entry_match)
  );

  assign access_onehot = (access_reg == 3'b001) || (access_reg == 3'b010) ||
                         (access_reg == 3'b100);

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    allow_next     = allow_reg;
    found_next     = found_reg;
    match_idx_next = match_idx_reg;
    capture        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req_valid_i) begin
          capture    = 1'b1;
          idx_next   = '0;
          state_next = S_SETUP;
        end
      end
      S_SETUP: state_next = S_EVAL;
      S_EVAL: begin
        if (entry_match) begin
          state_next     = S_RESP;
          found_next     = 1'b1;
          match_idx_next = idx_reg;
          allow_next     = access_onehot &
                           ((priv_m_reg & ~cur_cfg[7]) | (|(access_reg & cur_cfg[2:0])));
        end else if (idx_reg == LAST_IDX) begin
          state_next     = S_RESP;
          found_next     = 1'b0;
          match_idx_next = '0;
          allow_next     = access_onehot & priv_m_reg;
        end else begin
          idx_next   = idx_reg + 4'd1;
          state_next = S_SETUP;
        end
      end
      S_RESP: begin
        if (resp_ready_i) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= S_IDLE;
      idx_reg       <= '0;
      addr_reg      <= '0;
      access_reg    <= '0;
      priv_m_reg    <= 1'b0;
      allow_reg     <= 1'b0;
      found_reg     <= 1'b0;
      match_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      allow_reg     <= allow_next;
      found_reg     <= found_next;
      match_idx_reg <= match_idx_next;
      if (capture) begin
        addr_reg   <= addr_i;
        access_reg <= access_i;
        priv_m_reg <= priv_m_i;
      end
    end
  end

  assign req_ready_o   = (state_reg == S_IDLE);
  assign resp_valid_o  = (state_reg == S_RESP);
  assign allow_o       = allow_reg;
  assign match_found_o = found_reg;
  assign match_idx_o   = match_idx_reg;
endmodule
